// File: rtl/if_fetch_ctrl.sv
// Purpose : front-end controller sequencing the PC register, the IF/ID register and the
//           single-outstanding instruction-memory request/acknowledge handshake.
// Latency : enables, flush, bubble and imem_req_o are combinational from state and inputs;
//           fetch_err_o is registered (visible the cycle after the timeout is detected).
// Backpressure: a slow imem_ack_i holds the PC and feeds NOPs into ID; a load-use hazard
//           freezes PC and IF/ID; a fetch waiting TIMEOUT_CYC cycles is abandoned and flagged.
//
// Ports: clk_i/rst_i (sync, active-high); Branch_taken_i/Jump_i redirect from ID;
//        ID_EX_MemRead_i/ID_EX_RegRt_i/IF_ID_RegRs_i/IF_ID_RegRt_i load-use detection;
//        imem_req_o/imem_ack_i fetch handshake; PC_Write_o, IF_ID_Write_o, IF_Flush_o,
//        ID_EX_Bubble_o pipeline controls; fetch_err_o sticky timeout flag.
// Optional: define IF_FETCH_CTRL_PERF_EN to add stall_cnt_o / flush_cnt_o counters.
module if_fetch_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Branch_taken_i,
  input  logic        Jump_i,
  input  logic        ID_EX_MemRead_i,
  input  logic [4:0]  ID_EX_RegRt_i,
  input  logic [4:0]  IF_ID_RegRs_i,
  input  logic [4:0]  IF_ID_RegRt_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  output logic        PC_Write_o,
  output logic        IF_ID_Write_o,
  output logic        IF_Flush_o,
  output logic        ID_EX_Bubble_o,
  output logic        fetch_err_o
`ifdef IF_FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  // S_RUN  : a request is issued every cycle.
  // S_WAIT : request outstanding, its word is still wanted.
  // S_DRAIN: request outstanding, its word will be thrown away on arrival.
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q;
  logic            redirect, lu, timeout;
  logic            req_c, pcw_c, ifw_c, flush_c, bubble_c;

  assign redirect = Branch_taken_i | Jump_i;
  assign lu = ID_EX_MemRead_i && (ID_EX_RegRt_i != 5'd0) &&
              ((ID_EX_RegRt_i == IF_ID_RegRs_i) || (ID_EX_RegRt_i == IF_ID_RegRt_i));

  always_comb begin
    state_d  = state_q;
    req_c    = 1'b0;
    pcw_c    = 1'b0;
    ifw_c    = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_RUN: begin
        req_c = 1'b1;
        if (redirect) begin
          pcw_c   = 1'b1;
          ifw_c   = 1'b1;
          flush_c = 1'b1;
          if (!imem_ack_i) state_d = S_DRAIN;
        end else if (lu) begin
          // The in-flight request is dropped; PC is held so it is refetched later.
          bubble_c = 1'b1;
          if (!imem_ack_i) state_d = S_DRAIN;
        end else if (imem_ack_i) begin
          pcw_c = 1'b1;
          ifw_c = 1'b1;
        end else begin
          ifw_c   = 1'b1;
          flush_c = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pcw_c   = 1'b1;
          ifw_c   = 1'b1;
          flush_c = 1'b1;
          state_d = imem_ack_i ? S_RUN : S_DRAIN;
        end else if (lu) begin
          bubble_c = 1'b1;
          if (imem_ack_i) state_d = S_RUN;
        end else if (imem_ack_i) begin
          pcw_c   = 1'b1;
          ifw_c   = 1'b1;
          state_d = S_RUN;
        end else begin
          ifw_c   = 1'b1;
          flush_c = 1'b1;
        end
      end
      S_DRAIN: begin
        flush_c = 1'b1;
        ifw_c   = 1'b1;
        if (redirect) begin
          pcw_c = 1'b1;
        end else if (lu) begin
          ifw_c    = 1'b0;
          bubble_c = 1'b1;
        end
        if (imem_ack_i) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    // Give up on a request that has waited too long; a late ack is then taken
    // as the ack of the next request issued from RUN.
    if ((state_q != S_RUN) && !imem_ack_i && (cnt_q == TO_W'(TIMEOUT_CYC - 1))) begin
      timeout = 1'b1;
      state_d = S_RUN;
    end

    // Counter stays at zero in RUN, so the first WAIT/DRAIN cycle sees zero.
    if ((state_q == S_RUN) || (state_d == S_RUN)) cnt_d = '0;
    else                                          cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (timeout) err_q <= 1'b1;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign imem_req_o     = req_c    & ~rst_i;
  assign PC_Write_o     = pcw_c    & ~rst_i;
  assign IF_ID_Write_o  = ifw_c    & ~rst_i;
  assign IF_Flush_o     = flush_c  & ~rst_i;
  assign ID_EX_Bubble_o = bubble_c & ~rst_i;
  assign fetch_err_o    = err_q;

`ifdef IF_FETCH_CTRL_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PC_Write_o) stall_q <= stall_q + 32'd1;
      if (IF_Flush_o)  flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
`endif

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Front-end pipeline controller that sequences the PC register and the IF/ID pipeline register.
- Generates PC_Write_o, IF_ID_Write_o, IF_Flush_o and ID_EX_Bubble_o from three events:
  - branch/jump redirects resolved in ID;
  - load-use hazards;
  - the request/acknowledge handshake with instruction memory, which may take several cycles.
- Sits between the hazard/branch logic in ID, the PC register, the IF/ID register and the instruction memory port.

Parameters:
- TIMEOUT_CYC, 255, maximum wait cycles for imem_ack_i before abandoning a fetch.
- TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- Branch_taken_i  in  1  taken branch resolved in ID this cycle.
- Jump_i  in  1  jump decoded in ID this cycle.
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- ID_EX_RegRt_i  in  5  load destination register.
- IF_ID_RegRs_i  in  5  rs of the instruction in ID.
- IF_ID_RegRt_i  in  5  rt of the instruction in ID.
- imem_req_o  out  1  issues a fetch for the current PC.
- imem_ack_i  in  1  fetch data valid; single-cycle pulse.
- PC_Write_o  out  1  PC loads its next value (PC+4 or target, selected externally).
- IF_ID_Write_o  out  1  IF/ID register load enable.
- IF_Flush_o  out  1  IF/ID loads a NOP (all zeros) instead of the fetched word.
- ID_EX_Bubble_o  out  1  zero the control fields entering ID/EX.
- fetch_err_o  out  1  sticky fetch-timeout flag.

Behaviour:

Reset and timing:
- Reset is synchronous, active-high.
- While rst_i=1, all outputs are 0.
- After reset: state = RUN, timeout counter = 0, fetch_err_o = 0.
- All outputs except fetch_err_o are combinational from state and inputs.
- fetch_err_o is registered.

Event definitions:
- redirect = Branch_taken_i | Jump_i.
- lu = ID_EX_MemRead_i & (ID_EX_RegRt_i != 0) & (ID_EX_RegRt_i == IF_ID_RegRs_i | ID_EX_RegRt_i == IF_ID_RegRt_i).
- Priority: redirect > lu > fetch progress.

Memory protocol:
- At most one request outstanding.
- A request is issued in any cycle where imem_req_o=1.
- The acknowledge may arrive in the same cycle (hit) or in a later cycle.

State RUN:
- imem_req_o = 1.
- redirect:
  - PC_Write=1, IF_ID_Write=1, IF_Flush=1.
  - If ack=0, next state = DRAIN; otherwise stay in RUN.
- Else lu:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - If ack=0, next state = DRAIN (the request is abandoned and PC is refetched later).
- Else ack=1: PC_Write=1, IF_ID_Write=1, IF_Flush=0.
- Else (ack=0): PC_Write=0, IF_ID_Write=1, IF_Flush=1 (NOP into ID); next state = WAIT.

State WAIT:
- imem_req_o = 0; the timeout counter increments each cycle.
- redirect: PC_Write=1, IF_ID_Write=1, IF_Flush=1.
  - If ack=1, next state = RUN (the wrong-path word is discarded); otherwise next state = DRAIN.
- Else lu: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - If ack=1, the word is discarded and next state = RUN (the same PC is refetched).
- Else ack=1: PC_Write=1, IF_ID_Write=1, IF_Flush=0; next state = RUN.
- Else: PC_Write=0, IF_ID_Write=1, IF_Flush=1.

State DRAIN:
- imem_req_o = 0; IF_Flush=1 and IF_ID_Write=1, except during lu, when IF_ID_Write=0.
- redirect: PC_Write=1. Otherwise PC_Write=0. lu also asserts Bubble.
- ack=1: the word is discarded; next state = RUN.

Timeout:
- The counter clears on entry to RUN.
- When the counter reaches TIMEOUT_CYC in WAIT or DRAIN:
  - fetch_err_o is set to 1 and held until reset;
  - next state = RUN;
  - a late ack that arrives while in RUN is treated as the new request's ack.

Other rules:
- Redirect and lu in the same cycle: redirect wins and Bubble = 0.
- Reset asserted mid-wait: state returns to RUN; the outstanding request is forgotten.

Optional Feature:
- Macro: IF_FETCH_CTRL_PERF_EN.
- When defined:
  - Adds outputs stall_cnt_o [31:0] and flush_cnt_o [31:0].
  - stall_cnt_o increments each cycle in which PC_Write_o=0 and rst_i=0.
  - flush_cnt_o increments each cycle in which IF_Flush_o=1.
  - Both counters reset to 0 and wrap modulo 2^32.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Reset, then ack=1 every cycle for 5 cycles, no hazards -> PC_Write=IF_ID_Write=1 and IF_Flush=0 each cycle; state stays RUN.
2. Ack delayed 3 cycles -> cycle 0: req=1, IF_Flush=1, PC_Write=0; cycles 1-2: PC_Write=0, IF_Flush=1; cycle 3 (ack): PC_Write=1, IF_Flush=0.
3. ID_EX_MemRead=1, RegRt=5, IF_ID_RegRs=5, ack=1 -> PC_Write=0, IF_ID_Write=0, Bubble=1 for 1 cycle. Repeat with RegRt=0 -> no stall.
4. Branch_taken=1 in WAIT with ack=0 -> PC_Write=1, IF_Flush=1, state DRAIN. Ack 2 cycles later -> word discarded; next cycle RUN with req=1.
5. TIMEOUT_CYC=4, no ack -> fetch_err_o rises after 4 WAIT cycles and stays 1 until rst_i=1.
6. With IF_FETCH_CTRL_PERF_EN defined, scenario 2 -> stall_cnt_o=3 and flush_cnt_o=3.
